imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 16-bit instruction words stored (power of two, 16..4096).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the response buffer depth and the maximum outstanding request count.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  fetch requester presents an address.
REQ-006 req_ready  output  1  responder accepts the request this cycle.
REQ-007 req_addr  input  16  byte address of the instruction (PC).
REQ-008 flush  input  1  branch taken; discard all outstanding work.
REQ-009 rsp_valid  output  1  response word available.
REQ-010 rsp_ready  input  1  requester consumes the response this cycle.
REQ-011 rsp_instr  output  16  instruction word.
REQ-012 rsp_addr  output  16  byte address the response belongs to.
REQ-013 rsp_err  output  1  misaligned or out-of-range request.
REQ-014 load_en  input  1  program-load write strobe.
REQ-015 load_addr  input  16  byte address of load write; bit 0 ignored.
REQ-016 load_data  input  16  word to write.

Function
REQ-017 Request SHALL be accepted in a cycle where req_valid and req_ready are both 1.
REQ-018 outstanding = requests in read pipeline + FIFO entries; req_ready SHALL be 1 iff outstanding < FIFO_DEPTH, computed from registered state only (no dependence on req_valid/rsp_ready).
REQ-019 Request accepted in cycle T SHALL produce rsp_valid no earlier than cycle T+2 (stage 1: array read registered; stage 2: FIFO write); with empty FIFO, exactly T+2.
REQ-020 Responses SHALL be returned in acceptance order; back-to-back requests with rsp_ready held 1 SHALL sustain one response per cycle.
REQ-021 A response SHALL pop when rsp_valid and rsp_ready are 1; rsp_instr/rsp_addr/rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-022 Word index = req_addr[15:1]; req_addr[0]=1 or index >= DEPTH_WORDS SHALL give rsp_err=1 and rsp_instr=16'h0000 (NOP); otherwise rsp_err=0 and stored word.
REQ-023 load_en=1 SHALL write load_data to word load_addr[15:1] at the clock edge; out-of-range load SHALL be ignored; load is always accepted (no backpressure).
REQ-024 Load and request to the same word in the same cycle SHALL return the pre-write (old) word.
REQ-025 flush=1 SHALL invalidate all pipeline entries and FIFO entries at that edge; rsp_valid SHALL be 0 in cycle T+1 after flush in T.
REQ-026 A request accepted in the same cycle as flush SHALL be kept (it is the branch target) and respond at T+2.
REQ-027 Outstanding counter SHALL never exceed FIFO_DEPTH nor underflow; simultaneous accept and pop SHALL leave it unchanged.
REQ-028 rsp_valid=0 SHALL imply rsp_err=0 and rsp_instr/rsp_addr don't-care.

Reset
REQ-029 rst=1 SHALL clear pipeline valids, FIFO pointers and outstanding count; next cycle rsp_valid=0, req_ready=1.
REQ-030 Reset mid-operation SHALL drop all in-flight responses identically to flush; memory contents SHALL NOT be cleared.
REQ-031 rst SHALL take priority over flush, load_en and request acceptance (no load write during rst).

Structure
REQ-032 Package imem_pkg SHALL hold ADDR_W=16, INSTR_W=16, NOP_INSTR=16'h0000 and the response record (instr, addr, err).
REQ-033 Response buffer SHALL be one sub-module, resp_fifo (synchronous FIFO, registered outputs, count output); array and read pipeline remain in imem_responder.

Verification
REQ-034 Load words 0..3 = 1111,2222,3333,4444; requests 0,2,4,6 back-to-back, rsp_ready=1 -> responses 1111..4444 on cycles T+2..T+5, rsp_err=0.
REQ-035 rsp_ready=0, issue 6 requests -> req_ready drops after 4 accepted; raise rsp_ready -> 4 responses in order, then remaining 2 accepted.
REQ-036 Request 0x0003 and 0x0200 (DEPTH 256) -> rsp_err=1, rsp_instr=0000 each.
REQ-037 Three requests outstanding, flush with new request 0x0010 same cycle -> only response addr 0x0010 appears, at T+2.
REQ-038 Same-cycle load 0x0004<=ABCD and request 0x0004 (old 3333) -> 3333; repeat request -> ABCD.
REQ-039 rst asserted with 2 outstanding -> next cycle rsp_valid=0, req_ready=1; memory readback unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder:
//   ADDR_W / INSTR_W  - byte-address and instruction widths
//   NOP_INSTR         - word returned for faulting fetches
//   resp_t            - one response record (instr, addr, err)
//   word_in_range()   - checks a word index against the array depth
// ---------------------------------------------------------------------------
package imem_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  addr;
      logic               err;
   } resp_t;

   // Word index is the byte address without bit 0; zero-extend to 32 bits so
   // the comparison against the integer depth has matching widths.
   function automatic logic word_in_range(input logic [ADDR_W-2:0] idx,
                                          input int unsigned       depth);
      return ({{(32 - (ADDR_W - 1)){1'b0}}, idx} < depth);
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// ---------------------------------------------------------------------------
// resp_fifo
// Synchronous response buffer. Entries are kept in a shift register so the
// head record is driven straight from flops (registered outputs).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clr          - discard every stored entry at this edge
//   push, push_data - write one record (ignored when full)
//   pop          - remove the head record (ignored when empty)
//   head         - oldest record
//   valid        - buffer holds at least one record
//   count        - number of stored records
// ---------------------------------------------------------------------------
module resp_fifo
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  resp_t            push_data,
   input  logic             pop,
   output resp_t            head,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   resp_t            entries_q [DEPTH];
   resp_t            entries_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] base_s;
   logic             do_pop_s;

   // Next-state: clear wins; otherwise shift out on pop, then append the push
   // behind whatever remains so a simultaneous pop and push keeps the count.
   always_comb begin
      entries_d = entries_q;
      count_d   = count_q;
      base_s    = count_q;
      do_pop_s  = pop & (count_q != {CNT_W{1'b0}});

      if (clr) begin
         count_d = {CNT_W{1'b0}};
      end else begin
         if (do_pop_s) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
               entries_d[i] = entries_q[i + 1];
            end
            base_s = count_q - CNT_W'(1);
         end else begin
            base_s = count_q;
         end

         if (push && (base_s < CNT_W'(DEPTH))) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               if (CNT_W'(i) == base_s) begin
                  entries_d[i] = push_data;
               end else begin
                  entries_d[i] = entries_d[i];
               end
            end
            count_d = base_s + CNT_W'(1);
         end else begin
            count_d = base_s;
         end
      end
   end

   // Occupancy register; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   // Payload storage; contents beyond count_q are don't-care, so no reset.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

   assign head  = entries_q[0];
   assign valid = (count_q != {CNT_W{1'b0}});
   assign count = count_q;

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Instruction memory with a fetch request/response interface.
//   Stage 1: accepted request reads the word array into a register.
//   Stage 2: the registered result is written into resp_fifo, whose head is
//            presented on the response port.
// A program-load port writes the array with no backpressure. flush drops all
// in-flight work but keeps a request accepted in the same cycle (branch
// target). Reset clears pipeline/FIFO state, never the array.
// Ports:
//   clk, rst                               - clock, sync active-high reset
//   req_valid/req_ready/req_addr           - fetch request (byte address)
//   flush                                  - discard outstanding work
//   rsp_valid/rsp_ready/rsp_instr/rsp_addr/rsp_err - fetch response
//   load_en/load_addr/load_data            - program-load write port
// ---------------------------------------------------------------------------
module imem_responder
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_instr,
   output logic [15:0] rsp_addr,
   output logic        rsp_err,
   input  logic        load_en,
   input  logic [15:0] load_addr,
   input  logic [15:0] load_data
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [INSTR_W-1:0] mem_q [DEPTH_WORDS];

   logic          s1_valid_q;
   logic          s1_valid_d;
   resp_t         s1_rsp_q;
   resp_t         s1_rsp_d;

   logic          accept_s;
   logic          req_err_s;
   logic          req_ready_s;
   logic [CW-1:0] outstanding_s;
   logic          push_s;
   logic          pop_s;
   logic          mem_we_s;
   logic          load_lsb_unused_s;

   resp_t         fifo_head_s;
   logic          fifo_valid_s;
   logic [CW-1:0] fifo_count_s;

   // Bit 0 of a load address carries no information for word writes.
   assign load_lsb_unused_s = load_addr[0];

   // Handshake, read-stage and write-port decode. req_ready depends only on
   // flops, so a requester may use it combinationally without a loop.
   always_comb begin
      outstanding_s = fifo_count_s + CW'(s1_valid_q);
      req_ready_s   = (outstanding_s < CW'(FIFO_DEPTH));
      accept_s      = req_valid & req_ready_s & ~rst;
      req_err_s     = req_addr[0] | ~word_in_range(req_addr[ADDR_W-1:1], DEPTH_WORDS);

      // A single stage: whatever sat in stage 1 moves on (or is flushed),
      // so the stage is occupied next cycle exactly when a request lands now.
      s1_valid_d = accept_s;
      if (accept_s) begin
         s1_rsp_d.addr = req_addr;
         s1_rsp_d.err  = req_err_s;
         if (req_err_s) begin
            s1_rsp_d.instr = NOP_INSTR;
         end else begin
            // Array read before this edge's load write: same-word collision
            // returns the old word.
            s1_rsp_d.instr = mem_q[req_addr[AW:1]];
         end
      end else begin
         s1_rsp_d = s1_rsp_q;
      end

      push_s   = s1_valid_q & ~flush;
      pop_s    = fifo_valid_s & rsp_ready;
      mem_we_s = load_en & ~rst & word_in_range(load_addr[ADDR_W-1:1], DEPTH_WORDS);
   end

   // Stage-1 valid: reset dominates; flush is absorbed because s1_valid_d
   // only reflects this cycle's acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
      end
   end

   // Stage-1 payload; meaningful only while s1_valid_q is set.
   always_ff @(posedge clk) begin
      s1_rsp_q <= s1_rsp_d;
   end

   // Instruction array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[load_addr[AW:1]] <= load_data;
      end
   end

   resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CW)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (push_s),
      .push_data (s1_rsp_q),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .valid     (fifo_valid_s),
      .count     (fifo_count_s)
   );

   assign req_ready = req_ready_s;
   assign rsp_valid = fifo_valid_s;
   assign rsp_instr = fifo_head_s.instr;
   assign rsp_addr  = fifo_head_s.addr;
   // Error flag is forced low whenever no response is presented.
   assign rsp_err   = fifo_head_s.err & fifo_valid_s;

endmodule
